// File: rtl/seg_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : seg_pkg
// Brief    : Shared segment patterns, decode codes and capture FSM states.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package seg_pkg;

   // Segment patterns a..g, MSB = a, 1 = lit
   localparam logic [6:0] SEG_0     = 7'b1111110;
   localparam logic [6:0] SEG_1     = 7'b0110000;
   localparam logic [6:0] SEG_2     = 7'b1101101;
   localparam logic [6:0] SEG_3     = 7'b1111001;
   localparam logic [6:0] SEG_4     = 7'b0110011;
   localparam logic [6:0] SEG_5     = 7'b1011011;
   localparam logic [6:0] SEG_6     = 7'b1011111;
   localparam logic [6:0] SEG_7     = 7'b1110000;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1111011;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   localparam logic [3:0] DIG_BLANK = 4'hF;
   localparam logic [3:0] DIG_BAD   = 4'hE;

   typedef enum logic [0:0] {
      HUNT    = 1'b0,
      CAPTURE = 1'b1
   } cap_state_t;

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : seg7_decode
// Brief    : Combinational seven-segment pattern to BCD decoder.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module seg7_decode
   import seg_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] code,
   output logic       bad
);

   always_comb begin
      code = DIG_BAD;
      bad  = 1'b0;
      case (seg)
         SEG_0:     code = 4'd0;
         SEG_1:     code = 4'd1;
         SEG_2:     code = 4'd2;
         SEG_3:     code = 4'd3;
         SEG_4:     code = 4'd4;
         SEG_5:     code = 4'd5;
         SEG_6:     code = 4'd6;
         SEG_7:     code = 4'd7;
         SEG_8:     code = 4'd8;
         SEG_9:     code = 4'd9;
         SEG_BLANK: code = DIG_BLANK;
         default: begin
            code = DIG_BAD;
            bad  = 1'b1;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/seg_scan_capture.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : seg_scan_capture
// Brief    : Captures a multiplexed 8-digit seven-segment scan back into BCD.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module seg_scan_capture
   import seg_pkg::*;
#(
   parameter int STABLE_FRAMES = 2
) (
   input  logic        iclk,
   input  logic        nrst,
   input  logic [7:0]  cathodes,
   input  logic [7:0]  anodes,
   output logic [31:0] digits,
   output logic [7:0]  dots,
   output logic        frame_valid,
   output logic        frame_err,
   output logic        stable
);

   localparam logic [3:0] c_stable_th = 4'(STABLE_FRAMES);

   logic [7:0]  r_an_q;
   logic [7:0]  r_ca_q;
   cap_state_t  r_state;
   logic [2:0]  r_exp;
   logic        r_bad;
   logic [4:0]  r_shadow [8];
   logic [3:0]  r_same_cnt;

   logic [3:0]  w_code;
   logic        w_dig_bad;
   logic        w_dp;
   logic [3:0]  w_act_cnt;
   logic [2:0]  w_idx;
   logic        w_one;
   logic        w_multi;
   logic [31:0] w_pub_digits;
   logic [7:0]  w_pub_dots;
   logic        w_same;

   seg7_decode u_decode (
      .seg  (r_ca_q[7:1]),
      .code (w_code),
      .bad  (w_dig_bad)
   );

   assign w_dp = r_ca_q[0];

   // Anode bit 7 is digit 0, so the index counts down from the MSB
   always_comb begin
      w_act_cnt = 4'd0;
      w_idx     = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (r_an_q[i]) begin
            w_act_cnt = w_act_cnt + 4'd1;
            w_idx     = 3'(7 - i);
         end
      end
   end

   assign w_one   = (w_act_cnt == 4'd1);
   assign w_multi = (w_act_cnt > 4'd1);

   // Publish view includes the slot-7 value arriving this cycle
   always_comb begin
      w_pub_digits = '0;
      w_pub_dots   = '0;
      for (int i = 0; i < 7; i++) begin
         w_pub_digits[31-4*i -: 4] = r_shadow[i][4:1];
         w_pub_dots[7-i]           = r_shadow[i][0];
      end
      w_pub_digits[3:0] = w_code;
      w_pub_dots[0]     = w_dp;
   end

   assign w_same = (w_pub_digits == digits) && (w_pub_dots == dots);
   assign stable = (r_same_cnt >= c_stable_th);

   always_ff @(posedge iclk or negedge nrst) begin
      if (!nrst) begin
         r_an_q      <= '0;
         r_ca_q      <= '0;
         r_state     <= HUNT;
         r_exp       <= 3'd0;
         r_bad       <= 1'b0;
         r_same_cnt  <= 4'd0;
         digits      <= '0;
         dots        <= '0;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            r_shadow[i] <= '0;
         end
      end else begin
         r_an_q      <= ~anodes;
         r_ca_q      <= ~cathodes;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         case (r_state)
            HUNT: begin
               if (w_one && (w_idx == 3'd0)) begin
                  r_shadow[0] <= {w_code, w_dp};
                  r_exp       <= 3'd1;
                  r_bad       <= w_dig_bad;
                  r_state     <= CAPTURE;
               end
            end
            CAPTURE: begin
               if (w_one && (w_idx == r_exp - 3'd1)) begin
                  // Slow scan: same digit held for several cycles
                  r_shadow[w_idx] <= {w_code, w_dp};
                  r_bad           <= r_bad | w_dig_bad;
               end else if (w_one && (w_idx == r_exp)) begin
                  r_shadow[w_idx] <= {w_code, w_dp};
                  if (w_idx == 3'd7) begin
                     digits      <= w_pub_digits;
                     dots        <= w_pub_dots;
                     frame_valid <= 1'b1;
                     frame_err   <= r_bad | w_dig_bad;
                     r_bad       <= 1'b0;
                     r_state     <= HUNT;
                     if ((r_same_cnt == 4'd0) || !w_same) begin
                        r_same_cnt <= 4'd1;
                     end else if (r_same_cnt != 4'hF) begin
                        r_same_cnt <= r_same_cnt + 4'd1;
                     end
                  end else begin
                     r_bad <= r_bad | w_dig_bad;
                     r_exp <= r_exp + 3'd1;
                  end
               end else if (w_one || w_multi) begin
                  frame_err <= 1'b1;
                  r_bad     <= 1'b0;
                  for (int i = 0; i < 8; i++) begin
                     r_shadow[i] <= '0;
                  end
                  if (w_one && (w_idx == 3'd0)) begin
                     r_shadow[0] <= {w_code, w_dp};
                     r_exp       <= 3'd1;
                     r_bad       <= w_dig_bad;
                  end else begin
                     r_state <= HUNT;
                  end
               end
            end
            default: r_state <= HUNT;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_capture.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_seg_scan_capture
// Brief    : Self-checking bench for seg_scan_capture with a frame-level model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_seg_scan_capture;

   logic        iclk = 1'b0;
   logic        nrst = 1'b0;
   logic [7:0]  cathodes = 8'hFF;
   logic [7:0]  anodes = 8'hFF;
   logic [31:0] digits;
   logic [7:0]  dots;
   logic        frame_valid;
   logic        frame_err;
   logic        stable;

   int total = 0;
   int bad = 0;
   int n_valid = 0;
   int n_err = 0;
   logic [41:0] pubq[$];

   always #5 iclk = ~iclk;

   seg_scan_capture #(.STABLE_FRAMES(2)) dut (
      .iclk        (iclk),
      .nrst        (nrst),
      .cathodes    (cathodes),
      .anodes      (anodes),
      .digits      (digits),
      .dots        (dots),
      .frame_valid (frame_valid),
      .frame_err   (frame_err),
      .stable      (stable)
   );

   // Pulse recorder; sampled shortly after each active edge
   always @(posedge iclk) begin
      #2;
      if (frame_valid) begin
         n_valid++;
         pubq.push_back({digits, dots, frame_err, stable});
      end
      if (frame_err) n_err++;
   end

   // Nibble E stands for an undecodable pattern, F for a blank digit
   function automatic logic [6:0] seg_of(input logic [3:0] d);
      case (d)
         4'd0: return 7'b1111110;
         4'd1: return 7'b0110000;
         4'd2: return 7'b1101101;
         4'd3: return 7'b1111001;
         4'd4: return 7'b0110011;
         4'd5: return 7'b1011011;
         4'd6: return 7'b1011111;
         4'd7: return 7'b1110000;
         4'd8: return 7'b1111111;
         4'd9: return 7'b1111011;
         4'hF: return 7'b0000000;
         default: return 7'b1010101;
      endcase
   endfunction

   task automatic put(input int idx, input logic [3:0] d, input logic dp);
      logic [7:0] one;
      @(negedge iclk);
      one      = 8'h80 >> idx;
      anodes   = ~one;
      cathodes = ~{seg_of(d), dp};
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge iclk);
         anodes   = 8'hFF;
         cathodes = 8'hFF;
      end
   endtask

   task automatic scan_frame(input logic [31:0] d, input logic [7:0] dp);
      for (int i = 0; i < 8; i++) put(i, d[31-4*i -: 4], dp[7-i]);
   endtask

   task automatic pulse_reset();
      @(negedge iclk);
      nrst = 1'b0;
      idle(2);
      nrst = 1'b1;
      idle(1);
   endtask

   task automatic test_reset();
      idle(2);
      total++; if (digits !== 32'h0) begin bad++; $display("FAIL reset_digits got=%h want=0", digits); end
      total++; if (dots !== 8'h0) begin bad++; $display("FAIL reset_dots got=%h want=0", dots); end
      total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL reset_fv got=%b want=0", frame_valid); end
      total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_fe got=%b want=0", frame_err); end
      total++; if (stable !== 1'b0) begin bad++; $display("FAIL reset_stable got=%b want=0", stable); end
      nrst = 1'b1;
      idle(3);
      total++; if (n_valid + n_err !== 0) begin bad++; $display("FAIL reset_release_pulse got=%0d want=0", n_valid + n_err); end
   endtask

   task automatic test_basic();
      int v0;
      v0 = n_valid;
      scan_frame(32'h1211_1967, 8'b0101_0000);
      idle(1);
      @(negedge iclk);
      total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL basic_fv got=%b want=1", frame_valid); end
      total++; if (digits !== 32'h1211_1967) begin bad++; $display("FAIL basic_digits got=%h want=12111967", digits); end
      total++; if (dots !== 8'b0101_0000) begin bad++; $display("FAIL basic_dots got=%b want=01010000", dots); end
      total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL basic_fe got=%b want=0", frame_err); end
      @(negedge iclk);
      total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL basic_fv_width got=%b want=0", frame_valid); end
      total++; if (n_valid !== v0 + 1) begin bad++; $display("FAIL basic_count got=%0d want=%0d", n_valid, v0 + 1); end
   endtask

   task automatic test_stable();
      logic [31:0] f;
      logic        want;
      pulse_reset();
      for (int k = 0; k < 4; k++) begin
         f    = (k == 3) ? 32'h1211_1968 : 32'h1211_1967;
         want = (k == 1) || (k == 2);
         scan_frame(f, 8'b0101_0000);
         idle(1);
         @(negedge iclk);
         total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL stable_fv%0d got=%b want=1", k, frame_valid); end
         total++; if (stable !== want) begin bad++; $display("FAIL stable_frame%0d got=%b want=%b", k, stable, want); end
      end
   endtask

   task automatic test_order_abort();
      int v0, e0;
      v0 = n_valid; e0 = n_err;
      put(0, 4'd1, 1'b0); put(1, 4'd2, 1'b0); put(2, 4'd3, 1'b0); put(4, 4'd5, 1'b0);
      idle(2);
      total++; if (n_err !== e0 + 1) begin bad++; $display("FAIL abort_err got=%0d want=%0d", n_err - e0, 1); end
      total++; if (n_valid !== v0) begin bad++; $display("FAIL abort_novalid got=%0d want=0", n_valid - v0); end
      scan_frame(32'h0123_4567, 8'hA5);
      idle(1);
      @(negedge iclk);
      total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL abort_next_fv got=%b want=1", frame_valid); end
      total++; if (digits !== 32'h0123_4567) begin bad++; $display("FAIL abort_next_digits got=%h want=01234567", digits); end
      total++; if (dots !== 8'hA5) begin bad++; $display("FAIL abort_next_dots got=%h want=a5", dots); end
      total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL abort_next_fe got=%b want=0", frame_err); end
   endtask

   task automatic test_collision_idle();
      int v0, e0;
      v0 = n_valid; e0 = n_err;
      put(0, 4'd4, 1'b0); put(1, 4'd4, 1'b0); put(2, 4'd4, 1'b0);
      @(negedge iclk);
      anodes   = ~8'b0000_1100;
      cathodes = ~{seg_of(4'd4), 1'b0};
      idle(2);
      total++; if (n_err !== e0 + 1) begin bad++; $display("FAIL collision_err got=%0d want=1", n_err - e0); end
      total++; if (n_valid !== v0) begin bad++; $display("FAIL collision_novalid got=%0d want=0", n_valid - v0); end
      for (int i = 0; i < 8; i++) begin
         put(i, 4'(9 - i), i[0]);
         if (i < 7) idle(5);
      end
      idle(1);
      @(negedge iclk);
      total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL gap_fv got=%b want=1", frame_valid); end
      total++; if (digits !== 32'h9876_5432) begin bad++; $display("FAIL gap_digits got=%h want=98765432", digits); end
      total++; if (dots !== 8'h55) begin bad++; $display("FAIL gap_dots got=%h want=55", dots); end
   endtask

   task automatic test_bad_blank();
      scan_frame(32'h0123_4E67, 8'h00);
      idle(1);
      @(negedge iclk);
      total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL bad_fv got=%b want=1", frame_valid); end
      total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL bad_fe got=%b want=1", frame_err); end
      total++; if (digits !== 32'h0123_4E67) begin bad++; $display("FAIL bad_digits got=%h want=01234e67", digits); end
      scan_frame(32'h3F45_6789, 8'h80);
      idle(1);
      @(negedge iclk);
      total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL blank_fv got=%b want=1", frame_valid); end
      total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL blank_fe got=%b want=0", frame_err); end
      total++; if (digits !== 32'h3F45_6789) begin bad++; $display("FAIL blank_digits got=%h want=3f456789", digits); end
   endtask

   task automatic test_reset_mid();
      int v0, e0;
      for (int i = 0; i < 4; i++) put(i, 4'd8, 1'b1);
      put(4, 4'd8, 1'b1);
      #2 nrst = 1'b0;
      #1;
      total++; if ({digits, dots, frame_valid, frame_err, stable} !== 43'h0) begin bad++; $display("FAIL midreset_outputs got=%h want=0", {digits, dots, frame_valid, frame_err, stable}); end
      v0 = n_valid; e0 = n_err;
      idle(2);
      nrst = 1'b1;
      idle(3);
      total++; if ((n_valid - v0) + (n_err - e0) !== 0) begin bad++; $display("FAIL midreset_pulse got=%0d want=0", (n_valid - v0) + (n_err - e0)); end
      scan_frame(32'h2468_1357, 8'h0F);
      idle(1);
      @(negedge iclk);
      total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL midreset_fv got=%b want=1", frame_valid); end
      total++; if (digits !== 32'h2468_1357) begin bad++; $display("FAIL midreset_digits got=%h want=24681357", digits); end
      total++; if (stable !== 1'b0) begin bad++; $display("FAIL midreset_stable got=%b want=0", stable); end
   endtask

   // Random frames with slow digits, idle gaps and back-to-back scans
   task automatic test_random();
      logic [41:0] expq[$];
      logic [39:0] prev;
      logic [31:0] d;
      logic [7:0]  dp;
      logic        err;
      int          cnt, r;
      pulse_reset();
      pubq.delete();
      cnt  = 0;
      prev = '0;
      for (int f = 0; f < 40; f++) begin
         if (f > 0 && ($urandom_range(0, 1) == 1)) begin
            {d, dp} = prev;
         end else begin
            for (int i = 0; i < 8; i++) begin
               r = $urandom_range(0, 23);
               d[31-4*i -: 4] = (r < 10) ? 4'(r) : (r < 23) ? 4'hF : 4'hE;
               if (r >= 10 && r < 20) d[31-4*i -: 4] = 4'(r - 10);
            end
            dp = 8'($urandom);
         end
         err = 1'b0;
         for (int i = 0; i < 8; i++) if (d[31-4*i -: 4] == 4'hE) err = 1'b1;
         if (cnt == 0 || {d, dp} != prev) cnt = 1;
         else if (cnt < 15) cnt = cnt + 1;
         prev = {d, dp};
         expq.push_back({d, dp, err, (cnt >= 2)});
         for (int i = 0; i < 8; i++) begin
            put(i, d[31-4*i -: 4], dp[7-i]);
            if ($urandom_range(0, 3) == 0) put(i, d[31-4*i -: 4], dp[7-i]);
            if (i < 7 && $urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
         end
         r = $urandom_range(0, 2);
         if (r > 0) idle(r);
      end
      idle(3);
      total++; if (pubq.size() !== expq.size()) begin bad++; $display("FAIL rand_count got=%0d want=%0d", pubq.size(), expq.size()); end
      for (int k = 0; k < expq.size() && k < pubq.size(); k++) begin
         total++;
         if (pubq[k] !== expq[k]) begin
            bad++;
            $display("FAIL rand_frame%0d got=%h want=%h", k, pubq[k], expq[k]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stable();
      test_order_abort();
      test_collision_idle();
      test_bad_blank();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
